// File: rtl/led_pkg.sv
// Shared types and constants for the LED shift-register serializer.
package led_pkg;

    localparam int unsigned LED_DATA_BITS   = 16;
    localparam int unsigned LED_DIV_DEFAULT = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } led_tx_state_t;

    // Half-period counter width; a divide-by-one still needs one bit.
    function automatic int unsigned div_cnt_width(input int unsigned div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Half-period timer: tick is high in the last cycle of every DIV-cycle phase.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int unsigned DIV = LED_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = div_cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_tick;

    always_comb begin
        w_cnt_nxt = '0;
        if (!restart && (r_cnt != LAST)) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    // Tick is looked ahead from the next count so it can be a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= (LAST == '0);
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= (w_cnt_nxt == LAST);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/led_serial_tx.sv
// MSB-first serializer for a 74HC595-style LED chain, latching after each frame.
module led_serial_tx
    import led_pkg::*;
#(
    parameter int unsigned DATA_BITS       = LED_DATA_BITS,
    parameter int unsigned DATA_COUNT_BITS = 4,
    parameter int unsigned DIV             = LED_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] par_data,
    output logic                 led_clk,
    output logic                 led_sout,
    output logic                 led_clrn,
    output logic                 led_pen,
    output logic                 busy,
    output logic                 done
);

    localparam logic [DATA_COUNT_BITS-1:0] LAST_BIT = DATA_COUNT_BITS'(DATA_BITS - 1);

    led_tx_state_t              r_state;
    led_tx_state_t              w_state_nxt;
    logic [DATA_BITS-1:0]       r_shift;
    logic [DATA_BITS-1:0]       w_shift_nxt;
    logic [DATA_COUNT_BITS-1:0] r_bit_cnt;
    logic [DATA_COUNT_BITS-1:0] w_bit_cnt_nxt;
    logic                       w_tick;
    logic                       w_restart;

    logic r_led_clk, r_led_sout, r_led_clrn, r_led_pen, r_busy, r_done;
    logic w_clk_nxt, w_sout_nxt, w_pen_nxt, w_busy_nxt, w_done_nxt;

    led_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(w_restart),
        .tick   (w_tick)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    // Next state and next output values; outputs follow the state by one cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_clk_nxt     = 1'b0;
        w_sout_nxt    = r_led_sout;
        w_pen_nxt     = r_led_pen;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = SHIFT_LO;
                    w_shift_nxt   = par_data;
                    w_bit_cnt_nxt = '0;
                end
            end
            SHIFT_LO: begin
                w_sout_nxt = r_shift[DATA_BITS-1];
                w_pen_nxt  = 1'b0;
                w_busy_nxt = 1'b1;
                if (w_tick) begin
                    w_state_nxt = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                w_clk_nxt  = 1'b1;
                w_pen_nxt  = 1'b0;
                w_busy_nxt = 1'b1;
                if (w_tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = LATCH;
                    end else begin
                        w_state_nxt   = SHIFT_LO;
                        w_shift_nxt   = {r_shift[DATA_BITS-2:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + DATA_COUNT_BITS'(1);
                    end
                end
            end
            LATCH: begin
                w_pen_nxt   = 1'b1;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_restart = (r_state == IDLE) || (w_state_nxt != r_state);
    end

    // Output registers; clrn drops only while reset is applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led_clk  <= 1'b0;
            r_led_sout <= 1'b0;
            r_led_clrn <= 1'b0;
            r_led_pen  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_led_clk  <= w_clk_nxt;
            r_led_sout <= w_sout_nxt;
            r_led_clrn <= 1'b1;
            r_led_pen  <= w_pen_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign led_clk  = r_led_clk;
    assign led_sout = r_led_sout;
    assign led_clrn = r_led_clrn;
    assign led_pen  = r_led_pen;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: doc/led_serial_tx.md
# led_serial_tx

Serializer that drives the board's external LED shift-register chain (74HC595-style). It takes a parallel LED word from the SPIO output stage and shifts it out MSB-first on a serial clock/data pair, then pulses the latch/enable line. One frame is sent per accepted `start`.

## Interface
Parameters:
- `DATA_BITS`, 16, frame width in bits.
- `DATA_COUNT_BITS`, 4, bit-counter width; must satisfy 2^DATA_COUNT_BITS >= DATA_BITS.
- `DIV`, 1, system-clock cycles per serial half-period (>= 1).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, active-low, synchronous.
- `start`  in  1  frame request; sampled only in IDLE.
- `par_data`  in  DATA_BITS  word to send; captured on the accepting edge.
- `led_clk`  out  1  serial shift clock to the chain.
- `led_sout`  out  1  serial data; valid whenever `led_clk` rises.
- `led_clrn`  out  1  chain clear, active-low.
- `led_pen`  out  1  latch/output enable; rising edge latches the chain.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse in the LATCH cycle.

## Operation
- Reset (`rst_n`=0 at a rising edge): state IDLE, `led_clk`=0, `led_sout`=0, `led_clrn`=0, `led_pen`=0, `busy`=0, `done`=0, shift register and counters cleared. In the first cycle after reset, `led_clrn`=1 and remains 1.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: if `start`=1, capture `par_data` into the shift register and the bit counter. Then go to SHIFT_LO, with `busy`=1 and `led_pen`=0.
- SHIFT_LO: `led_clk`=0 and `led_sout`=shift register MSB, held for DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: `led_clk`=1 for DIV cycles. On exit:
  - If DATA_BITS bits have been sent, go to LATCH.
  - Otherwise shift left by 1, increment the bit counter, and go to SHIFT_LO.
- LATCH (one cycle): `led_clk`=0, `led_pen`=1, `done`=1, `busy`=1. Then go to IDLE.
- IDLE holds `led_pen`=1 after the first frame; 0 before any frame since reset. `led_sout` holds its last value.
- `start` while `busy`=1 is ignored and not queued. `par_data` changes mid-frame have no effect.
- Bit order: `par_data[DATA_BITS-1]` first, bit 0 last.
- Half-period counter runs 0..DIV-1 and reloads on each phase change.
- Reset mid-frame: the frame is abandoned. All outputs take their reset values at the next edge, including `led_clrn`=0, which clears the partial chain.
- `start` and `rst_n`=0 in the same cycle: reset wins and no frame starts.

## Timing
- Notation: N=DATA_BITS. Cycle 0 is the edge where `start` is accepted.
- Bit i (0-based, MSB first):
  - `led_clk` low during cycles 1+2i·DIV .. (2i+1)·DIV.
  - `led_clk` high during cycles 1+(2i+1)·DIV .. (2i+2)·DIV.
- LATCH is cycle 2N·DIV+1; IDLE is entered at 2N·DIV+2.
- `busy` is high for exactly 2N·DIV+1 cycles.
- `start` held high continuously starts the next frame at the edge ending the first IDLE cycle. The minimum `busy`-low gap is 1 cycle.
- `led_sout` is stable for DIV cycles before and DIV cycles after each `led_clk` rise (DIV=1: one cycle each side).

## Structure
- Shared package `led_pkg`:
  - state enum `led_tx_state_t` (IDLE, SHIFT_LO, SHIFT_HI, LATCH);
  - constants `LED_DATA_BITS`=16 and `LED_DIV_DEFAULT`=1;
  - a `clog2`-based width function for the DIV counter.
- One sub-module, `led_tick_gen`:
  - produces a one-cycle `tick` every DIV cycles;
  - has a synchronous `restart` input that reloads it on every phase change.
  - The FSM advances phases on `tick`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Basic frame, N=16, DIV=1: `par_data`=16'hA55A, pulse `start` at cycle 0.
  - Bits sampled on `led_clk` rises are 1010010101011010.
  - `led_pen` rises and `done`=1 at cycle 33; `busy` falls at cycle 34.
- Busy ignore: second `start` with 16'hFFFF at cycle 10 of the 16'h0001 frame.
  - Only the 16'h0001 frame is sent (15 zeros then a 1).
  - `done` pulses once.
- Reset mid-frame: `rst_n`=0 at cycle 12.
  - At cycle 13: `led_clrn`=0, `led_clk`=0, `busy`=0, `led_pen`=0.
  - After release: `led_clrn`=1 and a new `start` sends a full frame.
- Divider, DIV=3, 16'h8000: each `led_clk` phase lasts 3 cycles; first rise at cycle 4; `done` at cycle 97.
- Back-to-back, `start` held high: frames begin at cycles 0 and 34; `busy` is low only in cycle 33→34; `done` pulses at cycles 33 and 67.
- Reset/start collision: `rst_n`=0 and `start`=1 in the same cycle → no frame; `busy` stays 0.
